sseg_mux_core: RTL

Memory-mapped 8-digit seven-segment display controller occupying one slot of the MMIO subsystem, directly downstream of the FPro MMIO bus. Software writes raw segment patterns, brightness and a digit mask over the slot bus. The core time-multiplexes the patterns onto the shared active-low `an`/`sseg` pins of the board with a free-running refresh counter and PWM dimming, so the processor never services the display in real time.

---
 rtl/sseg_mux_core.sv | 105 ++++++++++
 1 files changed

// File: rtl/sseg_mux_core.sv
// Memory-mapped 8-digit seven-segment controller: raw segment patterns, PWM brightness
// and a digit mask are time-multiplexed onto shared active-low an/sseg pins.
module sseg_mux_core #(
    parameter int DIV_W = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cs,
    input  logic        read,
    input  logic        write,
    input  logic [4:0]  addr,
    input  logic [31:0] wr_data,
    output logic [31:0] rd_data,
    output logic [7:0]  an,
    output logic [7:0]  sseg
);

    localparam logic [DIV_W-1:0] DIV_ONE = {{(DIV_W-1){1'b0}}, 1'b1};
    localparam logic [DIV_W-1:0] DIV_MAX = {DIV_W{1'b1}};

    logic [63:0]      pat_r;
    logic [3:0]       bright_r;
    logic             en_r;
    logic [7:0]       mask_r;
    logic [DIV_W-1:0] div_cnt_r;
    logic [2:0]       idx_r;
    logic [7:0]       an_r;
    logic [7:0]       sseg_r;
    logic             wr_en_s;
    logic             on_s;
    logic             unused_s;

    // Reads have no side effects, so the read strobe carries no information here.
    assign unused_s = read;
    assign wr_en_s  = cs & write;
    assign on_s     = en_r & mask_r[idx_r] & (div_cnt_r[DIV_W-1 -: 4] <= bright_r);

    // Software-visible registers: patterns and control.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pat_r    <= {64{1'b1}};
            bright_r <= 4'hf;
            en_r     <= 1'b1;
            mask_r   <= 8'hff;
        end else if (wr_en_s) begin
            case (addr)
                5'd0: pat_r[31:0]  <= wr_data;
                5'd1: pat_r[63:32] <= wr_data;
                5'd2: begin
                    bright_r <= wr_data[3:0];
                    en_r     <= wr_data[4];
                    mask_r   <= wr_data[15:8];
                end
                default: pat_r <= pat_r;
            endcase
        end else begin
            pat_r <= pat_r;
        end
    end

    // Free-running refresh divider; digit index advances as the divider wraps to zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt_r <= {DIV_W{1'b0}};
            idx_r     <= 3'd0;
        end else begin
            div_cnt_r <= div_cnt_r + DIV_ONE;
            if (div_cnt_r == DIV_MAX) begin
                idx_r <= idx_r + 3'd1;
            end else begin
                idx_r <= idx_r;
            end
        end
    end

    // Output register: exactly one digit enable low while on, all-ones while off.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            an_r   <= 8'hff;
            sseg_r <= 8'hff;
        end else if (on_s) begin
            an_r   <= ~(8'h01 << idx_r);
            sseg_r <= pat_r[{idx_r, 3'b000} +: 8];
        end else begin
            an_r   <= 8'hff;
            sseg_r <= 8'hff;
        end
    end

    assign an   = an_r;
    assign sseg = sseg_r;

    // Zero-latency read mux, independent of cs.
    always_comb begin
        rd_data = 32'h0000_0000;
        case (addr)
            5'd0:    rd_data = pat_r[31:0];
            5'd1:    rd_data = pat_r[63:32];
            5'd2:    rd_data = {16'h0000, mask_r, 3'b000, en_r, bright_r};
            5'd3:    rd_data = {29'h0000_0000, idx_r};
            default: rd_data = 32'h0000_0000;
        endcase
    end

endmodule
